// File: rtl/seq_rshift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_rshift_pkg
// Brief    : State encoding and parameter defaults for the sequential shifter.
// Revision : 1.0
// ============================================================================
package seq_rshift_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_AMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : seq_rshift_pkg
`default_nettype wire

// File: rtl/seq_rshift_step.sv
`default_nettype none
// ============================================================================
// Module   : rshift_step
// Brief    : One-bit right shift with selectable sign or zero fill.
// Revision : 1.0
// ============================================================================
module rshift_step
    import seq_rshift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             is_signed,
    output logic [WIDTH-1:0] shifted
);

    logic fill;

    assign fill    = is_signed & data[WIDTH-1];
    assign shifted = (data >> 1) | {fill, {(WIDTH-1){1'b0}}};

endmodule : rshift_step
`default_nettype wire

// File: rtl/seq_rshift.sv
`default_nettype none
// ============================================================================
// Module   : seq_rshift
// Brief    : Multi-cycle right shifter, one bit per cycle, valid/ready ports.
// Revision : 1.0
// ============================================================================
module seq_rshift
    import seq_rshift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_data,
    input  logic [AMT_W-1:0] io_in_amt,
    input  logic             io_in_signed,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_data,
    output logic [7:0]       io_done_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_step;
    logic             sign_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       done_q;
    logic             in_fire;
    logic             out_fire;
    logic [31:0]      amt_wide;
    logic [CNT_W-1:0] k_amt;

    assign in_fire  = io_in_valid & io_in_ready;
    assign out_fire = io_out_valid & io_out_ready;

    // Amounts at or beyond WIDTH saturate: WIDTH steps already flush every bit.
    assign amt_wide = 32'(io_in_amt);
    assign k_amt    = (amt_wide >= 32'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(amt_wide);

    rshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data      (data_q),
        .is_signed (sign_q),
        .shifted   (data_step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_fire) begin
                    state_nxt = (k_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (in_fire) begin
                    state_nxt = (k_amt == '0) ? DONE : SHIFT;
                end else if (out_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io_in_ready  = 1'b0;
        io_out_valid = 1'b0;
        unique case (state)
            IDLE:    io_in_ready = 1'b1;
            SHIFT:   io_in_ready = 1'b0;
            DONE: begin
                io_in_ready  = io_out_ready;
                io_out_valid = 1'b1;
            end
            default: io_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            sign_q  <= 1'b0;
            count_q <= '0;
        end else if (in_fire) begin
            data_q  <= io_in_data;
            sign_q  <= io_in_signed;
            count_q <= k_amt;
        end else if (state == SHIFT) begin
            data_q  <= data_step;
            count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q <= '0;
        end else if (out_fire) begin
            done_q <= done_q + 8'd1;
        end
    end

    assign io_out_data   = data_q;
    assign io_done_count = done_q;

endmodule : seq_rshift
`default_nettype wire

// File: tb/tb_seq_rshift.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_rshift
// Brief    : Directed, table-driven bench for seq_rshift.
// Revision : 1.0
// ============================================================================
module tb_seq_rshift;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [15:0] io_in_data;
    logic [4:0]  io_in_amt;
    logic        io_in_signed;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [15:0] io_out_data;
    logic [7:0]  io_done_count;

    int compared   = 0;
    int mismatched = 0;
    int exp_count  = 0;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  amt;
        logic        sgn;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    always #5 clock = ~clock;

    seq_rshift #(
        .WIDTH (16),
        .AMT_W (5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_data    (io_in_data),
        .io_in_amt     (io_in_amt),
        .io_in_signed  (io_in_signed),
        .io_out_valid  (io_out_valid),
        .io_out_ready  (io_out_ready),
        .io_out_data   (io_out_data),
        .io_done_count (io_done_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!io_out_valid && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic handshake(input string name);
        io_out_ready = 1'b1;
        @(negedge clock);
        io_out_ready = 1'b0;
        exp_count++;
        chk({name, " done_count"}, 32'(io_done_count), 32'(exp_count % 256));
        chk({name, " idle_after"}, {31'd0, io_in_ready}, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string name);
        int cyc;
        @(negedge clock);
        chk({name, " in_ready"}, {31'd0, io_in_ready}, 32'd1);
        io_in_valid  = 1'b1;
        io_in_data   = v.data;
        io_in_amt    = v.amt;
        io_in_signed = v.sgn;
        @(negedge clock);
        io_in_valid  = 1'b0;
        io_in_data   = 16'h5A5A;
        wait_valid(cyc);
        chk({name, " latency"}, 32'(cyc), 32'(v.lat));
        chk({name, " data"}, 32'(io_out_data), 32'(v.exp));
        handshake(name);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [15:0] held;

        vecs[0]  = '{16'h8000, 5'd3,  1'b0, 16'h1000, 4};
        vecs[1]  = '{16'h8000, 5'd3,  1'b1, 16'hF000, 4};
        vecs[2]  = '{16'h7FFF, 5'd3,  1'b1, 16'h0FFF, 4};
        vecs[3]  = '{16'hFFFF, 5'd20, 1'b0, 16'h0000, 17};
        vecs[4]  = '{16'hFFFF, 5'd20, 1'b1, 16'hFFFF, 17};
        vecs[5]  = '{16'h1234, 5'd0,  1'b0, 16'h1234, 1};
        vecs[6]  = '{16'hB5C3, 5'd16, 1'b1, 16'hFFFF, 17};
        vecs[7]  = '{16'h8001, 5'd31, 1'b0, 16'h0000, 17};
        vecs[8]  = '{16'h8001, 5'd1,  1'b1, 16'hC000, 2};
        vecs[9]  = '{16'h8000, 5'd15, 1'b1, 16'hFFFF, 16};
        vecs[10] = '{16'h8000, 5'd15, 1'b0, 16'h0001, 16};

        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_data   = '0;
        io_in_amt    = '0;
        io_in_signed = 1'b0;
        io_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset in_ready",   {31'd0, io_in_ready},  32'd1);
        chk("reset out_valid",  {31'd0, io_out_valid}, 32'd0);
        chk("reset out_data",   32'(io_out_data),      32'd0);
        chk("reset done_count", 32'(io_done_count),    32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-amount result held under backpressure; in_* traffic must be ignored.
        @(negedge clock);
        io_in_valid = 1'b1; io_in_data = 16'h1234; io_in_amt = 5'd0; io_in_signed = 1'b0;
        @(negedge clock);
        io_in_data = 16'hFFFF; io_in_amt = 5'd2;
        chk("hold valid_lat1", {31'd0, io_out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold data c%0d", i), 32'(io_out_data), 32'h1234);
            chk($sformatf("hold in_ready c%0d", i), {31'd0, io_in_ready}, 32'd0);
            @(negedge clock);
        end
        io_in_valid = 1'b0;
        handshake("hold");

        // Back-to-back: result handed off in the same cycle as the next accept.
        @(negedge clock);
        io_in_valid = 1'b1; io_in_data = 16'h8000; io_in_amt = 5'd3; io_in_signed = 1'b0;
        @(negedge clock);
        io_in_valid = 1'b0;
        wait_valid(cyc);
        chk("b2b first data", 32'(io_out_data), 32'h1000);
        io_out_ready = 1'b1;
        io_in_valid = 1'b1; io_in_data = 16'h00F0; io_in_amt = 5'd4;
        @(negedge clock);
        io_in_valid = 1'b0; io_out_ready = 1'b0;
        exp_count++;
        chk("b2b no idle", {31'd0, io_in_ready}, 32'd0);
        chk("b2b count", 32'(io_done_count), 32'(exp_count % 256));
        wait_valid(cyc);
        chk("b2b latency", 32'(cyc), 32'd5);
        chk("b2b data", 32'(io_out_data), 32'h000F);
        handshake("b2b");

        // Reset in the middle of a long shift aborts it.
        @(negedge clock);
        io_in_valid = 1'b1; io_in_data = 16'hAAAA; io_in_amt = 5'd10; io_in_signed = 1'b1;
        @(negedge clock);
        io_in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort in_ready",   {31'd0, io_in_ready},  32'd1);
        chk("abort out_data",   32'(io_out_data),      32'd0);
        chk("abort done_count", 32'(io_done_count),    32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (io_out_valid) seen++;
            @(negedge clock);
        end
        chk("abort no valid", 32'(seen), 32'd0);
        exp_count = 0;

        // Stream 256 zero-amount operations to wrap the completion counter.
        io_in_valid = 1'b1; io_in_data = 16'h0042; io_in_amt = 5'd0; io_in_signed = 1'b0;
        io_out_ready = 1'b1;
        repeat (256) @(negedge clock);
        chk("wrap count 255", 32'(io_done_count), 32'd255);
        held = io_out_data;
        @(negedge clock);
        io_in_valid = 1'b0; io_out_ready = 1'b0;
        chk("wrap count 0", 32'(io_done_count), 32'd0);
        chk("wrap data", 32'(held), 32'h0042);
        chk("wrap valid", {31'd0, io_out_valid}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_seq_rshift
`default_nettype wire
